// File: rtl/uart_tx.sv
// UART transmit serializer: one frame per accepted byte,
// start + LSB-first data + optional parity + stop.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         cnt;
    logic                  par;
    logic                  par_en;
    logic                  par_typ;

    // Frame sequencer; outputs are registered from the current state,
    // so each line level appears one edge after its state is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            par     <= 1'b0;
            par_en  <= 1'b0;
            par_typ <= 1'b0;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        shift   <= P_DATA;
                        par_en  <= PAR_EN;
                        par_typ <= PAR_TYP;
                        state   <= START;
                    end
                end
                START: begin
                    TX_OUT <= 1'b0;
                    Busy   <= 1'b1;
                    cnt    <= '0;
                    // shift register still holds the untouched byte here
                    par    <= par_typ ? ~^shift : ^shift;
                    state  <= DATA;
                end
                DATA: begin
                    TX_OUT <= shift[0];
                    Busy   <= 1'b1;
                    shift  <= shift >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                    TX_OUT <= par;
                    Busy   <= 1'b1;
                    state  <= STOP;
                end
                STOP: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
